// File: rtl/dm_responder_if.sv
// Request/response/trace bundle between the M-stage (master) and the data-memory responder (slave).
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wr_trc_valid;
  logic [31:0] wr_trc_pc;
  logic [31:0] wr_trc_addr;
  logic [31:0] wr_trc_data;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           wr_trc_valid, wr_trc_pc, wr_trc_addr, wr_trc_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
           wr_trc_valid, wr_trc_pc, wr_trc_addr, wr_trc_data
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte-lane masked stores / full-word loads, registered response and store trace.
module dm_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Request captured at the accept edge (word address only; byte offset is ignored)
  logic           we_q, we_d;
  logic [29:0]    word_q, word_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    pc_q, pc_d;

  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic           trc_valid_q, trc_valid_d;
  logic [31:0]    trc_pc_q, trc_pc_d;
  logic [31:0]    trc_addr_q, trc_addr_d;
  logic [31:0]    trc_data_q, trc_data_d;

  logic [31:0]    mem_q [DEPTH];

  logic           accept_c;
  logic           access_c;
  logic           acc_we_c;
  logic [29:0]    acc_word_c;
  logic [3:0]     acc_be_c;
  logic [31:0]    acc_wdata_c;
  logic [31:0]    acc_pc_c;
  logic           in_range_c;
  logic [AW-1:0]  idx_c;
  logic [31:0]    old_word_c;
  logic [31:0]    merged_c;
  logic           mem_we_c;

  // Access operands: live inputs for a zero-wait access at accept, else the captured request
  always_comb begin
    accept_c    = bus.req_valid && req_ready_q && (state_q == S_IDLE);
    access_c    = ((state_q == S_IDLE) && accept_c && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == CW'(1)));
    acc_we_c    = we_q;
    acc_word_c  = word_q;
    acc_be_c    = be_q;
    acc_wdata_c = wdata_q;
    acc_pc_c    = pc_q;
    if (state_q == S_IDLE) begin
      acc_we_c    = bus.req_we;
      acc_word_c  = bus.req_addr[31:2];
      acc_be_c    = bus.req_be;
      acc_wdata_c = bus.req_wdata;
      acc_pc_c    = bus.req_pc;
    end
    in_range_c = (acc_word_c[29:AW] == '0);
    idx_c      = acc_word_c[AW-1:0];
    old_word_c = mem_q[idx_c];
    merged_c   = old_word_c;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc_be_c[i]) merged_c[8*i +: 8] = acc_wdata_c[8*i +: 8];
    end
    mem_we_c = access_c && acc_we_c && in_range_c && (acc_be_c != 4'b0000);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    word_d       = word_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    trc_valid_d  = 1'b0;
    trc_pc_d     = trc_pc_q;
    trc_addr_d   = trc_addr_q;
    trc_data_d   = trc_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          we_d    = bus.req_we;
          word_d  = bus.req_addr[31:2];
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          pc_d    = bus.req_pc;
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (access_c) begin
      resp_rdata_d = (!acc_we_c && in_range_c) ? old_word_c : 32'h0;
      resp_err_d   = !in_range_c;
      trc_valid_d  = mem_we_c;
      if (mem_we_c) begin
        trc_pc_d   = acc_pc_c;
        trc_addr_d = {acc_word_c, 2'b00};
        trc_data_d = merged_c;
      end
    end

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // Control, captured request and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      word_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      trc_valid_q  <= 1'b0;
      trc_pc_q     <= '0;
      trc_addr_q   <= '0;
      trc_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      word_q       <= word_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      trc_valid_q  <= trc_valid_d;
      trc_pc_q     <= trc_pc_d;
      trc_addr_q   <= trc_addr_d;
      trc_data_q   <= trc_data_d;
    end
  end

  // Word storage, cleared on reset, written with the lane-merged word at commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[idx_c] <= merged_c;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.wr_trc_valid = trc_valid_q;
  assign bus.wr_trc_pc    = trc_pc_q;
  assign bus.wr_trc_addr  = trc_addr_q;
  assign bus.wr_trc_data  = trc_data_q;

endmodule
